// File: rtl/duck_sprite_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// duck_sprite_scheduler : shares one duck sprite ROM among NUM_DUCKS objects,
// returning a palette index / valid / winning ID two clocks after the pixel.
// Revision 1.0
// ---------------------------------------------------------------------------
module duck_sprite_scheduler #(
  parameter int         NUM_DUCKS   = 4,
  parameter int         SPR_W       = 68,
  parameter int         SPR_H       = 64,
  parameter int         ANIM_FRAMES = 2,
  parameter int         ANIM_DIV    = 8,
  parameter int         ADDR_W      = 14,
  parameter logic [3:0] TRANSPARENT = 4'h0
) (
  input  logic                    vga_clk,
  input  logic                    Reset,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  input  logic                    frame_start,
  input  logic [10*NUM_DUCKS-1:0] duck_x,
  input  logic [10*NUM_DUCKS-1:0] duck_y,
  input  logic [NUM_DUCKS-1:0]    duck_en,
  input  logic [NUM_DUCKS-1:0]    duck_flip,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [3:0]              rom_q,
  output logic [3:0]              pix_index,
  output logic                    pix_valid,
  output logic [2:0]              pix_duck_id
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FRM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  logic [10*NUM_DUCKS-1:0] sh_x, sh_y;
  logic [NUM_DUCKS-1:0]    sh_en, sh_flip;
  logic [DIV_W-1:0]        div_cnt;
  logic [FRM_W-1:0]        anim_frame;

  // Object state only changes at frame boundaries so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sh_x       <= '0;
      sh_y       <= '0;
      sh_en      <= '0;
      sh_flip    <= '0;
      div_cnt    <= '0;
      anim_frame <= '0;
    end else if (frame_start) begin
      sh_x    <= duck_x;
      sh_y    <= duck_y;
      sh_en   <= duck_en;
      sh_flip <= duck_flip;
      if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
        div_cnt    <= '0;
        anim_frame <= (anim_frame == FRM_W'(ANIM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  logic [10:0]          px, py;
  logic [NUM_DUCKS-1:0] hit;

  assign px = {1'b0, DrawX};
  assign py = {1'b0, DrawY};

  // 11-bit compares keep a duck near the right/bottom edge from wrapping to 0.
  for (genvar i = 0; i < NUM_DUCKS; i++) begin : g_hit
    logic [10:0] x0, y0;
    assign x0 = {1'b0, sh_x[10*i +: 10]};
    assign y0 = {1'b0, sh_y[10*i +: 10]};
    assign hit[i] = sh_en[i] && blank &&
                    (px >= x0) && (px < x0 + 11'(SPR_W)) &&
                    (py >= y0) && (py < y0 + 11'(SPR_H));
  end

  logic        any_hit;
  logic [2:0]  win_id;
  logic [9:0]  x_win, y_win;
  logic        flip_win;

  always_comb begin
    any_hit  = 1'b0;
    win_id   = '0;
    x_win    = '0;
    y_win    = '0;
    flip_win = 1'b0;
    // Scan downwards so the lowest-index hit is the one left standing.
    for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_id   = 3'(i);
        x_win    = sh_x[10*i +: 10];
        y_win    = sh_y[10*i +: 10];
        flip_win = sh_flip[i];
      end
    end
  end

  logic [10:0]       col_raw, col, row;
  logic [ADDR_W-1:0] addr_next;

  assign col_raw   = px - {1'b0, x_win};
  assign col       = flip_win ? (11'(SPR_W - 1) - col_raw) : col_raw;
  assign row       = py - {1'b0, y_win};
  assign addr_next = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(row) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);

  logic       hit_d1;
  logic [2:0] id_d1;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_address <= '0;
      hit_d1      <= 1'b0;
      id_d1       <= '0;
      pix_index   <= '0;
      pix_valid   <= 1'b0;
      pix_duck_id <= '0;
    end else begin
      if (any_hit) rom_address <= addr_next;
      hit_d1      <= any_hit;
      id_d1       <= any_hit ? win_id : 3'd0;
      pix_index   <= hit_d1 ? rom_q : 4'd0;
      pix_valid   <= hit_d1 && (rom_q != TRANSPARENT);
      pix_duck_id <= id_d1;
    end
  end

endmodule
`default_nettype wire

// File: doc/duck_sprite_scheduler.md
Name: duck_sprite_scheduler

Overview:
- Shares one duck sprite ROM and palette-index path between NUM_DUCKS on-screen duck objects.
- For each pixel it picks the highest-priority duck covering (DrawX, DrawY), forms the ROM address (animation frame, optional horizontal flip) and drives the ROM.
- It returns a palette index, a valid flag and the winning duck ID, aligned 2 clocks after the pixel coordinate.
- It sits between the VGA controller, game logic and the sprite ROM/palette, ahead of the final colour mux.

Parameters:
- NUM_DUCKS, 4, number of duck objects (1..8).
- SPR_W, 68, sprite width in pixels.
- SPR_H, 64, sprite height in pixels.
- ANIM_FRAMES, 2, animation frames stored back-to-back in the ROM.
- ANIM_DIV, 8, video frames per animation step.
- ADDR_W, 14, ROM address width; must satisfy 2^ADDR_W >= ANIM_FRAMES*SPR_W*SPR_H.
- TRANSPARENT, 4'h0, palette index treated as see-through.

Ports:
- vga_clk  in  1  pixel clock; all state is on posedge.
- Reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active display region.
- frame_start  in  1  one-cycle pulse at the start of each video frame (vsync edge).
- duck_x  in  10*NUM_DUCKS  packed top-left X per duck; duck i is at [10i+9:10i].
- duck_y  in  10*NUM_DUCKS  packed top-left Y per duck.
- duck_en  in  NUM_DUCKS  per-duck enable.
- duck_flip  in  NUM_DUCKS  1 = mirror the duck horizontally.
- rom_address  out  ADDR_W  registered address to the sprite ROM.
- rom_q  in  4  ROM data; valid 1 vga_clk after rom_address changes.
- pix_index  out  4  palette index for the pixel.
- pix_valid  out  1  1 = a non-transparent duck pixel.
- pix_duck_id  out  3  index of the winning duck.

Behaviour:
- Reset: all outputs 0; shadow registers 0; anim_frame 0; div_cnt 0.
- Shadow latch:
  - On frame_start, duck_x, duck_y, duck_en and duck_flip are copied into shadow registers.
  - All hit tests use the shadow copies only, so there is no mid-frame tearing.
  - Values are held until the next frame_start.
- Animation counter:
  - On frame_start, div_cnt increments.
  - When div_cnt reaches ANIM_DIV-1, it wraps to 0 and anim_frame increments.
  - anim_frame wraps from ANIM_FRAMES-1 to 0.
  - Reset, when asserted together with frame_start, wins.
- Hit test (cycle t, combinational):
  - Duck i hits when shadow_en[i] && blank && x_i <= DrawX < x_i+SPR_W && y_i <= DrawY < y_i+SPR_H.
  - Comparisons are done in 11-bit arithmetic, so a duck at X = 1000 does not wrap.
  - Priority: lowest index wins.
- Stage 1 (posedge ending cycle t):
  - col = DrawX - x_win, or (SPR_W-1) - col when flip is set.
  - row = DrawY - y_win.
  - rom_address <= anim_frame*SPR_W*SPR_H + row*SPR_W + col.
  - hit_d1 and id_d1 are registered.
  - On no hit: rom_address holds its previous value and hit_d1 = 0.
- Stage 2 (next posedge):
  - pix_index <= rom_q.
  - pix_valid <= hit_d1 && (rom_q != TRANSPARENT).
  - pix_duck_id <= id_d1.
  - On no hit: pix_index = 0 and pix_duck_id = 0.
- Latency: exactly 2 vga_clk from DrawX/DrawY to pix_*, with a throughput of 1 pixel/clock.
- blank low: no hits, and pix_valid = 0 two cycles later.
- Overlaps: a transparent pixel of the winning duck yields pix_valid = 0; there is no fall-through to lower-priority ducks.
- Reset mid-line: the pipeline is flushed, and outputs return to 0 on the next edge.

Test Plan:
- Reset with stale pipeline contents -> all outputs 0; anim_frame 0.
- Single duck at (100,50), enabled, no flip, frame_start pulse, then pixel (100,50) -> rom_address = 0 one cycle later; pix_valid = rom_q != 0 at t+2. Pixel (167,113) -> address 4351. Pixel (168,50) -> pix_valid = 0.
- Same duck with flip = 1, pixel (100,50) -> rom_address = 67.
- Ducks 0 and 2 both at (200,200), pixel (210,205) -> pix_duck_id = 0, rom_address = 5*68+10 = 350. With duck 0 disabled after the next frame_start -> pix_duck_id = 2.
- duck_x changed mid-frame with no frame_start -> hits still use the old position. After frame_start -> the new position is used.
- 8 frame_start pulses -> anim_frame = 1; pixel at the duck origin -> rom_address = 4352. After 16 pulses -> wraps to 0.
- Duck at X = 1000, pixel (5,y) -> no hit, no wrap.
